// File: rtl/mux_nto1_scan.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nto1_scan
//  Purpose  : N-channel, DW-bit registered multiplexer with valid/ready output.
//             Direct mode follows i_sel every accepted cycle. Auto-scan mode
//             runs a sweep of all channels per i_start, with a dwell before
//             each capture.
//  Options  : MUX_SCAN_MASK_EN adds i_ch_mask. The scan then visits only the
//             enabled channels.
//  Revision : 1.0  initial release
// ============================================================================
module mux_nto1_scan #(
  parameter  int N_CH    = 16,
  parameter  int DW      = 1,
  parameter  int DWELL_W = 8,
  localparam int SELW    = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*DW-1:0]  i_din,
  input  logic                i_mode,
  input  logic [SELW-1:0]     i_sel,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic                i_start,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]     i_ch_mask,
`endif
  output logic [DW-1:0]       o_out_data,
  output logic [SELW-1:0]     o_out_ch,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SELW-1:0]      r_ch_cnt;
  logic [SELW-1:0]      w_ch_nxt;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [DWELL_W-1:0]   w_dwell_nxt;
  logic [DWELL_W-1:0]   w_dwell_eff;

  logic [DW-1:0]        r_out_data;
  logic [SELW-1:0]      r_out_ch;
  logic                 r_out_valid;
  logic                 r_last;
  logic                 r_done;

  logic                 w_load;
  logic                 w_start_ok;
  logic [SELW-1:0]      w_first;
  logic [SELW-1:0]      w_next;
  logic                 w_is_last;
  logic                 w_cap;
  logic [DW-1:0]        w_cap_data;
  logic [SELW-1:0]      w_cap_ch;
  logic                 w_cap_last;

  // Out-of-range indices (possible when N_CH is not a power of two) yield 0.
  function automatic logic [DW-1:0] f_pick(input logic [N_CH*DW-1:0] d,
                                           input logic [SELW-1:0]    idx);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == SELW'(i)) v = d[i*DW +: DW];
    end
    return v;
  endfunction

  assign w_load      = !r_out_valid || i_out_ready;
  assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

`ifdef MUX_SCAN_MASK_EN
  logic [N_CH-1:0] r_mask;

  // Channel sequencing over the mask frozen at start: first, next-higher, last.
  always_comb begin
    w_start_ok = i_start && i_mode && (|i_ch_mask);
    w_first    = '0;
    w_next     = r_ch_cnt;
    w_is_last  = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) w_first = SELW'(i);
      if (r_mask[i] && (SELW'(i) > r_ch_cnt)) begin
        w_next    = SELW'(i);
        w_is_last = 1'b0;
      end
    end
  end

  // Mask is captured only when a sweep is launched and held for its duration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_mask <= i_ch_mask;
    end
  end
`else
  assign w_start_ok = i_start && i_mode;
  assign w_first    = '0;
  assign w_next     = r_ch_cnt + SELW'(1);
  assign w_is_last  = (r_ch_cnt == SELW'(N_CH - 1));
`endif

  // Next-state logic and capture selection; leaving scan mode aborts a sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch_cnt;
    w_dwell_nxt = r_dwell_cnt;
    w_cap       = 1'b0;
    w_cap_data  = '0;
    w_cap_ch    = '0;
    w_cap_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_DWELL;
          w_ch_nxt    = w_first;
          w_dwell_nxt = w_dwell_eff;
        end else if (!i_mode && w_load) begin
          w_cap      = 1'b1;
          w_cap_data = f_pick(i_din, i_sel);
          w_cap_ch   = i_sel;
        end
      end
      S_DWELL: begin
        if (!i_mode) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else if (r_dwell_cnt <= DWELL_W'(1)) begin
          w_state_nxt = S_EMIT;
        end else begin
          w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
        end
      end
      S_EMIT: begin
        if (!i_mode) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else if (w_load) begin
          w_cap      = 1'b1;
          w_cap_data = f_pick(i_din, r_ch_cnt);
          w_cap_ch   = r_ch_cnt;
          w_cap_last = w_is_last;
          if (w_is_last) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = '0;
          end else begin
            w_state_nxt = S_DWELL;
            w_ch_nxt    = w_next;
            w_dwell_nxt = w_dwell_eff;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = '0;
      end
    endcase
  end

  // FSM state, channel and dwell counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_cnt    <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch_cnt    <= w_ch_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

  // Output register: capture on load, drop valid once an uncaptured sample is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= r_out_valid && i_out_ready && r_last;
      if (w_cap) begin
        r_out_data  <= w_cap_data;
        r_out_ch    <= w_cap_ch;
        r_out_valid <= 1'b1;
        r_last      <= w_cap_last;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
        r_last      <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_nto1_scan
//  Purpose  : Self-checking bench for mux_nto1_scan (N_CH=16, DW=1).
//             Define MUX_SCAN_MASK_EN to exercise the channel-mask build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        mode;
  logic [3:0]  sel;
  logic [7:0]  dwell;
  logic        start;
  logic [15:0] ch_mask;
  logic [0:0]  out_data;
  logic [3:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mux_nto1_scan #(.N_CH(16), .DW(1), .DWELL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_din       (din),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_dwell     (dwell),
    .i_start     (start),
`ifdef MUX_SCAN_MASK_EN
    .i_ch_mask   (ch_mask),
`endif
    .o_out_data  (out_data),
    .o_out_ch    (out_ch),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshakes and done pulses, checks valid samples are held.
  int         hs_ch[$];
  int         hs_dat[$];
  int         hs_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [3:0] pch = '0;
  logic [0:0] pd = '0;
  always @(negedge clk) begin
    if (pv && !pr && !prst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_ch", out_ch, pch);
      chk("hold_data", out_data, pd);
    end
    if (out_valid && out_ready && !rst) begin
      hs_ch.push_back(int'(out_ch));
      hs_dat.push_back(int'(out_data));
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    pv   <= out_valid;
    pr   <= out_ready;
    pch  <= out_ch;
    pd   <= out_data;
    prst <= rst;
  end

  // One scan sweep compared against the channel order the rules dictate.
  task automatic run_sweep(input string tag, input logic [7:0] dw, input logic [15:0] d,
                           input bit rnd, input int stall_ch, input bit spam, input bit timing);
    int deff;
    int hb;
    int db;
    int sc;
    int n;
    int stall_left;
    bit stalled;
    bit in_stall;
    int exp_list[$];
    deff = (dw == 0) ? 1 : int'(dw);
    stall_left = 0;
    stalled = 0;
    for (int c = 0; c < 16; c++) begin
`ifdef MUX_SCAN_MASK_EN
      if (ch_mask[c]) exp_list.push_back(c);
`else
      exp_list.push_back(c);
`endif
    end
    mode = 1'b1; dwell = dw; din = d; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
    hb = hs_ch.size();
    db = done_cnt;
    chk({tag, "_busy_start"}, busy, 1);
    n = 0;
    while (done_cnt == db && n < 3000) begin
      in_stall = 0;
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--; in_stall = 1;
      end else if (stall_ch >= 0 && !stalled && out_valid && int'(out_ch) == stall_ch) begin
        out_ready = 1'b0; stall_left = 4; stalled = 1; in_stall = 1;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      start = spam && busy && ($urandom_range(0, 3) == 0);
      tick();
      if (in_stall) begin
        chk({tag, "_stall_valid"}, out_valid, 1);
        chk({tag, "_stall_ch"}, out_ch, stall_ch);
      end
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_timeout"}, n < 3000, 1);
    tick();
    tick();
    chk({tag, "_count"}, hs_ch.size() - hb, exp_list.size());
    for (int k = 0; k < exp_list.size(); k++) begin
      if (hb + k < hs_ch.size()) begin
        chk({tag, "_ch"}, hs_ch[hb+k], exp_list[k]);
        chk({tag, "_data"}, hs_dat[hb+k], int'(d[exp_list[k]]));
        if (timing) chk({tag, "_cycle"}, hs_cyc[hb+k], sc + (k + 1) * (deff + 1));
      end
    end
    chk({tag, "_done_cnt"}, done_cnt - db, 1);
    if (hs_ch.size() > hb) chk({tag, "_done_cyc"}, done_cyc, hs_cyc[hs_ch.size()-1] + 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_valid_end"}, out_valid, 0);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] din;
    logic        ready;
    logic [3:0]  exp_ch;
    logic        exp_d;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    int db;
    logic       ev;
    logic [3:0] ec;
    logic       ed;

    rst = 1'b1; mode = 1'b0; sel = '0; dwell = '0; start = 1'b0;
    din = '0; out_ready = 1'b1; ch_mask = 16'hFFFF;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Direct mode: sweep sel, then backpressure holds the last sample.
    for (int i = 0; i < 16; i++) begin
      tbl[i].sel = 4'(i); tbl[i].din = 16'hAAAA; tbl[i].ready = 1'b1;
      tbl[i].exp_ch = 4'(i); tbl[i].exp_d = i[0];
    end
    tbl[16] = '{sel: 4'd3, din: 16'hAAAA, ready: 1'b0, exp_ch: 4'd15, exp_d: 1'b1};
    tbl[17] = '{sel: 4'd2, din: 16'hAAAA, ready: 1'b0, exp_ch: 4'd15, exp_d: 1'b1};
    tbl[18] = '{sel: 4'd2, din: 16'hAAAA, ready: 1'b1, exp_ch: 4'd2,  exp_d: 1'b0};
    tbl[19] = '{sel: 4'd2, din: 16'h0004, ready: 1'b1, exp_ch: 4'd2,  exp_d: 1'b1};
    for (int i = 0; i < 20; i++) begin
      sel = tbl[i].sel; din = tbl[i].din; out_ready = tbl[i].ready;
      tick();
      chk("dir_valid", out_valid, 1);
      chk("dir_ch", out_ch, tbl[i].exp_ch);
      chk("dir_data", out_data, tbl[i].exp_d);
    end

    // start with mode=0 is ignored.
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_mode0_busy", busy, 0);

    // Random direct mode against the load rule.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ev = 1'b0; ec = '0; ed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      din = 16'($urandom);
      sel = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if (!ev || out_ready) begin
        ev = 1'b1; ec = sel; ed = din[sel];
      end
      tick();
      chk("rdir_valid", out_valid, ev);
      chk("rdir_ch", out_ch, ec);
      chk("rdir_data", out_data, ed);
    end

    // Scan sweeps with fixed timing.
    run_sweep("scan_d2", 8'd2, 16'hAAAA, 0, -1, 0, 1);
    run_sweep("scan_d0", 8'd0, 16'h5A3C, 0, -1, 0, 1);
    run_sweep("scan_bp", 8'd2, 16'hAAAA, 0, 7, 0, 0);

    // Abort: leave scan mode while channel 4 is pending.
    mode = 1'b1; dwell = 8'd1; din = 16'hAAAA; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    db = done_cnt;
    n = 0;
    while (!(out_valid && out_ch == 4'd4) && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reach", n < 200, 1);
    out_ready = 1'b0; mode = 1'b0; sel = 4'd9;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 1);
    chk("abort_ch", out_ch, 4);
    tick();
    tick();
    chk("abort_hold_ch", out_ch, 4);
    out_ready = 1'b1;
    tick();
    chk("abort_dir_ch", out_ch, 9);
    chk("abort_dir_data", out_data, 1);
    tick();
    tick();
    chk("abort_no_done", done_cnt - db, 0);

    // Reset mid-sweep at channel 10, then a fresh sweep starts at channel 0.
    mode = 1'b1; dwell = 8'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_ch == 4'd10) && n < 200) begin
      tick();
      n++;
    end
    chk("rst_reach", n < 200, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ch", out_ch, 0);
    chk("midrst_done", done, 0);
    run_sweep("rescan", 8'd2, 16'hAAAA, 0, -1, 0, 1);

    // Randomised sweeps: random ready, data, dwell, extra start pulses.
    for (int i = 0; i < 5; i++) begin
      run_sweep("rnd", 8'($urandom_range(0, 3)), 16'($urandom), 1, -1, 1, 0);
    end

`ifdef MUX_SCAN_MASK_EN
    ch_mask = 16'h8421;
    run_sweep("mask", 8'd2, 16'hAAAA, 0, -1, 0, 0);
    run_sweep("mask_rnd", 8'd1, 16'($urandom), 1, -1, 1, 0);
    ch_mask = 16'h0000;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_busy", busy, 0);
    tick();
    chk("mask0_busy2", busy, 0);
    ch_mask = 16'hFFFF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
